// File: rtl/prt_rx_ingress.sv
// rtl/prt_rx_ingress.sv - MAC receive framer that claims, fills and commits/aborts PRT slots
// Bytes reach the PRT two cycles after acceptance; the commit/runt decision lands one cycle after the last write.
module prt_rx_ingress #(
    parameter int SLOT_W    = 2,
    parameter int MIN_BYTES = 64,
    parameter int MAX_BYTES = 1518,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_last_i,
    input  logic              prt_slot_free_i,
    input  logic [SLOT_W-1:0] prt_wr_slot_i,
    output logic              start_wr_prt_o,
    output logic              wr_en_o,
    output logic [7:0]        wr_data_o,
    output logic              finish_wr_prt_o,
    output logic              inv_slot_o,
    output logic [SLOT_W-1:0] inv_slot_idx_o,
    output logic              frame_done_valid_o,
    output logic [SLOT_W-1:0] frame_done_slot_o,
    output logic [15:0]       frame_done_len_o,
    output logic [CNT_W-1:0]  frames_ok_cnt_o,
    output logic [CNT_W-1:0]  frames_drop_cnt_o,
    output logic              busy_o
);

    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [15:0]      MIN_LEN  = 16'(MIN_BYTES);
    localparam logic [15:0]      MAX_LEN  = 16'(MAX_BYTES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP, S_HOLDOFF} state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              hold_q, hold_d;
    logic              pend_q, pend_d;

    logic              start_d, fwd_d, abort_d, commit_d, drop_inc_d;
    logic [15:0]       len_inc;

    logic              s1_wr_q;
    logic [7:0]        s1_data_q;
    logic              ab1_q;
    logic              c1_q, c2_q;

    logic              start_q, wr_en_q, finish_q, inv_q;
    logic [7:0]        wr_data_q;
    logic [SLOT_W-1:0] inv_idx_q, fd_slot_q;
    logic [15:0]       fd_len_q;
    logic [CNT_W-1:0]  ok_cnt_q, drop_cnt_q;

    logic              commit_ok, commit_bad, inv_next;

    assign len_inc = len_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        slot_d     = slot_q;
        gap_d      = gap_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        start_d    = 1'b0;
        fwd_d      = 1'b0;
        abort_d    = 1'b0;
        commit_d   = 1'b0;
        drop_inc_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    if (in_last_i) begin
                        drop_inc_d = 1'b1;
                        hold_d     = 1'b0;
                        state_d    = S_HOLDOFF;
                    end else if (prt_slot_free_i) begin
                        start_d = 1'b1;
                        fwd_d   = 1'b1;
                        slot_d  = prt_wr_slot_i;
                        len_d   = 16'd1;
                        gap_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        pend_d  = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
            S_WRITE: begin
                if (in_valid_i) begin
                    gap_d = '0;
                    if (len_q == MAX_LEN) begin
                        // Oversize: counted here so the trailing in_last is not counted again
                        abort_d    = 1'b1;
                        drop_inc_d = 1'b1;
                        pend_d     = 1'b0;
                        hold_d     = 1'b0;
                        state_d    = in_last_i ? S_HOLDOFF : S_DROP;
                    end else begin
                        len_d = len_inc;
                        fwd_d = 1'b1;
                        if (in_last_i) begin
                            commit_d   = 1'b1;
                            drop_inc_d = (len_inc < MIN_LEN);
                            hold_d     = 1'b0;
                            state_d    = S_HOLDOFF;
                        end
                    end
                end else if (gap_q == GAP_LAST) begin
                    abort_d    = 1'b1;
                    drop_inc_d = 1'b1;
                    pend_d     = 1'b0;
                    state_d    = S_DROP;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_DROP: begin
                if (in_valid_i && in_last_i) begin
                    drop_inc_d = pend_q;
                    pend_d     = 1'b0;
                    hold_d     = 1'b0;
                    state_d    = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                // Two quiet cycles keep the previous frame's commit pulse clear of a new start
                if (in_valid_i) begin
                    hold_d = 1'b0;
                    if (in_last_i) begin
                        drop_inc_d = 1'b1;
                    end else begin
                        pend_d  = 1'b1;
                        state_d = S_DROP;
                    end
                end else if (hold_q) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // len_q and slot_q stay stable until a new frame is claimed, which cannot precede the commit stage
    assign commit_ok  = c2_q && (len_q >= MIN_LEN);
    assign commit_bad = c2_q && (len_q < MIN_LEN);
    assign inv_next   = ab1_q || commit_bad;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            slot_q     <= '0;
            gap_q      <= '0;
            hold_q     <= 1'b0;
            pend_q     <= 1'b0;
            s1_wr_q    <= 1'b0;
            s1_data_q  <= '0;
            ab1_q      <= 1'b0;
            c1_q       <= 1'b0;
            c2_q       <= 1'b0;
            start_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            finish_q   <= 1'b0;
            inv_q      <= 1'b0;
            inv_idx_q  <= '0;
            fd_slot_q  <= '0;
            fd_len_q   <= '0;
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            slot_q     <= slot_d;
            gap_q      <= gap_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            s1_wr_q    <= fwd_d;
            s1_data_q  <= fwd_d ? in_data_i : 8'd0;
            ab1_q      <= abort_d;
            c1_q       <= commit_d;
            c2_q       <= c1_q;
            start_q    <= start_d;
            wr_en_q    <= s1_wr_q;
            wr_data_q  <= s1_wr_q ? s1_data_q : 8'd0;
            finish_q   <= commit_ok;
            inv_q      <= inv_next;
            inv_idx_q  <= inv_next ? slot_q : '0;
            fd_slot_q  <= commit_ok ? slot_q : '0;
            fd_len_q   <= commit_ok ? len_q : 16'd0;
            if (commit_ok && (ok_cnt_q != {CNT_W{1'b1}})) begin
                ok_cnt_q <= ok_cnt_q + CNT_W'(1);
            end
            if (drop_inc_d && (drop_cnt_q != {CNT_W{1'b1}})) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign start_wr_prt_o     = start_q;
    assign wr_en_o            = wr_en_q;
    assign wr_data_o          = wr_data_q;
    assign finish_wr_prt_o    = finish_q;
    assign inv_slot_o         = inv_q;
    assign inv_slot_idx_o     = inv_idx_q;
    assign frame_done_valid_o = finish_q;
    assign frame_done_slot_o  = fd_slot_q;
    assign frame_done_len_o   = fd_len_q;
    assign frames_ok_cnt_o    = ok_cnt_q;
    assign frames_drop_cnt_o  = drop_cnt_q;
    assign busy_o             = (state_q != S_IDLE);

endmodule

// File: tb/tb_prt_rx_ingress.sv
// tb/tb_prt_rx_ingress.sv - scoreboard bench for prt_rx_ingress
`timescale 1ns/1ps
module tb_prt_rx_ingress;

    localparam int MIN_B = 64;
    localparam int MAX_B = 1518;
    localparam int TMO   = 16;
    localparam int K_START = 0, K_WR = 1, K_FIN = 2, K_INV = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, slot_free;
    logic [7:0]  in_data;
    logic [1:0]  wr_slot;
    logic        start_o, wr_en, fin, inv, fdv, busy;
    logic [7:0]  wr_data;
    logic [1:0]  inv_idx, fd_slot;
    logic [15:0] fd_len, ok_cnt, drop_cnt;

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] val;
        logic [1:0]  slot;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    prt_rx_ingress dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .in_valid_i         (in_valid),
        .in_data_i          (in_data),
        .in_last_i          (in_last),
        .prt_slot_free_i    (slot_free),
        .prt_wr_slot_i      (wr_slot),
        .start_wr_prt_o     (start_o),
        .wr_en_o            (wr_en),
        .wr_data_o          (wr_data),
        .finish_wr_prt_o    (fin),
        .inv_slot_o         (inv),
        .inv_slot_idx_o     (inv_idx),
        .frame_done_valid_o (fdv),
        .frame_done_slot_o  (fd_slot),
        .frame_done_len_o   (fd_len),
        .frames_ok_cnt_o    (ok_cnt),
        .frames_drop_cnt_o  (drop_cnt),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int k, input int c, input logic [15:0] v, input logic [1:0] s);
        ev_t e;
        e.kind = k; e.cyc = c; e.val = v; e.slot = s;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input int k, input logic [15:0] v, input logic [1:0] s);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d slot=%0d at cycle %0d, required none", k, v, s, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v || e.slot != s) begin
                n_bad++;
                $display("FAIL event: got kind=%0d cyc=%0d val=%0d slot=%0d, required kind=%0d cyc=%0d val=%0d slot=%0d",
                         k, cyc, v, s, e.kind, e.cyc, e.val, e.slot);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a PRT-side pulse
    always @(negedge clk) begin
        if (mon_en) begin
            if (start_o || wr_en || fin || inv) begin
                n_cmp++;
                if ((int'(start_o) + int'(fin) + int'(inv) > 1) || (wr_en && (fin || inv)) || (fdv !== fin)) begin
                    n_bad++;
                    $display("FAIL exclusive: got start=%0b wr=%0b fin=%0b inv=%0b done=%0b, required one pulse and done==fin",
                             start_o, wr_en, fin, inv, fdv);
                end
            end
            if (start_o) check_ev(K_START, 16'd0, 2'd0);
            if (wr_en)   check_ev(K_WR, {8'd0, wr_data}, 2'd0);
            if (fin)     check_ev(K_FIN, fd_len, fd_slot);
            if (inv)     check_ev(K_INV, 16'd0, inv_idx);
        end
    end

    function automatic logic [7:0] byte_of(input int i, input int n);
        return 8'((i * 7 + n) & 255);
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame starting in the current cycle and queues the PRT activity it must cause
    task automatic send_frame(input int n, input int slot, input bit free, input int gap_pos,
                              input int gap_len, input bit claim);
        bit         fwd;
        logic [7:0] d;
        fwd = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_pos) begin
                for (int g = 1; g <= gap_len; g++) begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    if (fwd && g == TMO) begin
                        push(K_INV, cyc + 2, 16'd0, 2'(slot));
                        fwd = 1'b0;
                    end
                    @(posedge clk);
                    #1;
                end
            end
            d         = byte_of(i, n);
            in_valid  = 1'b1;
            in_data   = d;
            in_last   = (i == n - 1);
            slot_free = free;
            wr_slot   = 2'(slot);
            if (i == 0) begin
                if (n > 1 && free && claim) begin
                    fwd = 1'b1;
                    push(K_START, cyc + 1, 16'd0, 2'd0);
                    push(K_WR, cyc + 2, {8'd0, d}, 2'd0);
                end
            end else if (fwd) begin
                if (i + 1 > MAX_B) begin
                    push(K_INV, cyc + 2, 16'd0, 2'(slot));
                    fwd = 1'b0;
                end else begin
                    push(K_WR, cyc + 2, {8'd0, d}, 2'd0);
                    if (i == n - 1) begin
                        if (n >= MIN_B) push(K_FIN, cyc + 3, 16'(n), 2'(slot));
                        else            push(K_INV, cyc + 3, 16'd0, 2'(slot));
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        idle(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0;
        slot_free = 1'b0; wr_slot = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_pulses", {start_o, wr_en, fin, inv, fdv, busy}, 32'd0);
        check_val("reset_data", {wr_data, inv_idx, fd_slot, fd_len}, 32'd0);
        check_val("reset_cnts", {ok_cnt, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        send_frame(64, 2, 1'b1, -1, 0, 1'b1);
        drain("t1");
        check_val("t1_ok", ok_cnt, 1);
        check_val("t1_drop", drop_cnt, 0);

        send_frame(63, 2, 1'b1, -1, 0, 1'b1);
        drain("t2");
        check_val("t2_ok", ok_cnt, 1);
        check_val("t2_drop", drop_cnt, 1);

        send_frame(1600, 1, 1'b1, -1, 0, 1'b1);
        check_val("t3_busy_l1", busy, 1);
        @(posedge clk); #1;
        check_val("t3_busy_l2", busy, 1);
        @(posedge clk); #1;
        check_val("t3_busy_l3", busy, 0);
        drain("t3");
        check_val("t3_drop", drop_cnt, 2);

        send_frame(100, 3, 1'b0, -1, 0, 1'b1);
        drain("t4a");
        check_val("t4a_drop", drop_cnt, 3);
        send_frame(100, 3, 1'b1, -1, 0, 1'b1);
        drain("t4b");
        check_val("t4b_ok", ok_cnt, 2);

        send_frame(100, 1, 1'b1, 50, 16, 1'b1);
        drain("t5a");
        check_val("t5a_drop", drop_cnt, 4);
        check_val("t5a_ok", ok_cnt, 2);
        send_frame(100, 1, 1'b1, 50, 15, 1'b1);
        drain("t5b");
        check_val("t5b_ok", ok_cnt, 3);

        send_frame(64, 3, 1'b1, -1, 0, 1'b1);
        send_frame(64, 0, 1'b1, -1, 0, 1'b0);
        drain("t6a");
        check_val("t6a_ok", ok_cnt, 4);
        check_val("t6a_drop", drop_cnt, 5);
        send_frame(64, 0, 1'b1, -1, 0, 1'b1);
        idle(2);
        send_frame(70, 3, 1'b1, -1, 0, 1'b1);
        drain("t6b");
        check_val("t6b_ok", ok_cnt, 6);
        check_val("t6b_drop", drop_cnt, 5);

        send_frame(1, 2, 1'b1, -1, 0, 1'b1);
        drain("t7");
        check_val("t7_drop", drop_cnt, 6);
        check_val("t7_ok", ok_cnt, 6);

        mon_en = 1'b0;
        slot_free = 1'b1;
        wr_slot = 2'd2;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = 1'b0;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_pulses", {start_o, wr_en, fin, inv, fdv, busy}, 32'd0);
        check_val("rst_mid_cnts", {ok_cnt, drop_cnt}, 32'd0);
        check_val("rst_mid_data", {wr_data, inv_idx, fd_slot, fd_len}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        send_frame(64, 1, 1'b1, -1, 0, 1'b1);
        drain("t8");
        check_val("t8_ok", ok_cnt, 1);
        check_val("t8_drop", drop_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
